// File: rtl/multicycle_control.sv
// Control FSM for the multicycle CPU: sequences fetch/decode/execute/memory/writeback,
// decodes the IR opcode, and is the sole source of datapath write enables.
module multicycle_control #(
    parameter int OPW  = 6,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic            beq_flag,
    input  logic            mem_ready,
    output logic [3:0]      alu_sel,
    output logic            alu_a_sel,
    output logic [1:0]      alu_b_sel,
    output logic            mem_read,
    output logic            mem_write,
    output logic            iord,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            reg_write,
    output logic            wb_sel,
    output logic            retire,
    output logic            illegal,
    output logic            halted,
    output logic [CNTW-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // One bit per legal ALU code: mov, not, add, sub, or, and, slt, li.
    localparam logic [15:0] ALU_LEGAL_MASK = 16'h02BF;

    state_t            state_reg;
    state_t            state_next;
    logic [CNTW-1:0]   count_reg;

    logic is_rtype;
    logic is_itype;
    logic alu_code_ok;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_jmp;
    logic is_halt;
    logic is_legal;

    always_comb begin
        is_rtype    = (opcode[5:4] == 2'b00);
        is_itype    = (opcode[5:4] == 2'b01);
        alu_code_ok = ALU_LEGAL_MASK[opcode[3:0]];
        is_lw       = (opcode[5:0] == 6'b100000);
        is_sw       = (opcode[5:0] == 6'b100001);
        is_beq      = (opcode[5:0] == 6'b110000);
        is_jmp      = (opcode[5:0] == 6'b110001);
        is_halt     = (opcode[5:0] == 6'b111111);
        is_legal    = ((is_rtype || is_itype) && alu_code_ok)
                      || is_lw || is_sw || is_beq || is_jmp || is_halt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!is_legal) begin
                    state_next = S_FETCH;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_next = S_MEM;
                end else if (is_beq || is_jmp) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_next = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // Reset forces every output low so an aborted instruction cannot write or retire.
    always_comb begin
        alu_sel   = 4'b0000;
        alu_a_sel = 1'b0;
        alu_b_sel = 2'b00;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_a_sel = 1'b1;
                    alu_b_sel = 2'b01;
                    alu_sel   = 4'b0010;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_a_sel = 1'b1;
                    alu_b_sel = 2'b11;
                    alu_sel   = 4'b0010;
                    illegal   = !is_legal;
                    retire    = !is_legal;
                end
                S_EXEC: begin
                    if (is_lw || is_sw) begin
                        alu_b_sel = 2'b10;
                        alu_sel   = 4'b0010;
                    end else if (is_beq) begin
                        alu_sel  = 4'b0011;
                        pc_src   = 2'b01;
                        pc_write = beq_flag;
                        retire   = 1'b1;
                    end else if (is_jmp) begin
                        pc_src   = 2'b10;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end else begin
                        alu_sel   = opcode[3:0];
                        alu_b_sel = is_itype ? 2'b10 : 2'b00;
                    end
                end
                S_MEM: begin
                    iord      = 1'b1;
                    mem_read  = is_lw;
                    mem_write = is_sw;
                    retire    = is_sw && mem_ready;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = is_lw;
                    retire    = 1'b1;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (retire) begin
            count_reg <= count_reg + CNTW'(1);
        end
    end

    assign instr_count = rst ? '0 : count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, hand-written corner
// sequences, then random stimulus checked against a phase-queue reference model.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        beq_flag;
    logic        mem_ready;
    logic [3:0]  alu_sel;
    logic        alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic        wb_sel;
    logic        retire;
    logic        illegal;
    logic        halted;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    multicycle_control #(.OPW(6), .CNTW(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .beq_flag(beq_flag), .mem_ready(mem_ready),
        .alu_sel(alu_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
        .retire(retire), .illegal(illegal), .halted(halted), .instr_count(instr_count)
    );

    typedef struct packed {
        logic [3:0] alu_sel;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       wb_sel;
        logic       retire;
        logic       illegal;
        logic       halted;
    } outs_t;

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        flag;
        logic        rdy;
        outs_t       exp;
        logic [31:0] cnt;
    } vec_t;

    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;
    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_JMP = 5, C_HALT = 6, C_ILL = 7;

    outs_t       act;
    outs_t       last_act;
    vec_t        vecs[$];
    int          ph[$];
    logic [31:0] m_cnt;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    assign act = {alu_sel, alu_a_sel, alu_b_sel, mem_read, mem_write, iord, ir_write,
                  pc_write, pc_src, reg_write, wb_sel, retire, illegal, halted};

    function automatic outs_t mk(input logic [3:0] al, input logic a, input logic [1:0] b,
                                 input logic mr, input logic mw, input logic io,
                                 input logic irw, input logic pcw, input logic [1:0] pcs,
                                 input logic rw, input logic wb, input logic ret,
                                 input logic ill, input logic hlt);
        return {al, a, b, mr, mw, io, irw, pcw, pcs, rw, wb, ret, ill, hlt};
    endfunction

    function automatic int op_class(input logic [5:0] op);
        logic [3:0] code;
        logic       ok;
        code = op[3:0];
        ok = code inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd9};
        if (op[5:4] == 2'b00) return ok ? C_R : C_ILL;
        if (op[5:4] == 2'b01) return ok ? C_I : C_ILL;
        case (op)
            6'b100000: return C_LW;
            6'b100001: return C_SW;
            6'b110000: return C_BEQ;
            6'b110001: return C_JMP;
            6'b111111: return C_HALT;
            default:   return C_ILL;
        endcase
    endfunction

    // Model: the remaining phases of the current instruction; finishing the last one retires it.
    function automatic outs_t model_exp(input logic r, input logic [5:0] op,
                                        input logic f, input logic rd);
        outs_t e;
        int    cls;
        bit    last;
        e = '0;
        if (r) return e;
        cls  = op_class(op);
        last = (ph.size() == 1);
        case (ph[0])
            P_F: begin
                e.mem_read = 1'b1; e.alu_a_sel = 1'b1; e.alu_b_sel = 2'b01; e.alu_sel = 4'd2;
                e.ir_write = rd; e.pc_write = rd;
            end
            P_D: begin
                e.alu_a_sel = 1'b1; e.alu_b_sel = 2'b11; e.alu_sel = 4'd2;
                e.illegal = (cls == C_ILL); e.retire = (cls == C_ILL);
            end
            P_E: begin
                case (cls)
                    C_R:         e.alu_sel = op[3:0];
                    C_I:         begin e.alu_sel = op[3:0]; e.alu_b_sel = 2'b10; end
                    C_LW, C_SW:  begin e.alu_sel = 4'd2; e.alu_b_sel = 2'b10; end
                    C_BEQ:       begin e.alu_sel = 4'd3; e.pc_src = 2'b01; e.pc_write = f; e.retire = 1'b1; end
                    C_JMP:       begin e.pc_src = 2'b10; e.pc_write = 1'b1; e.retire = 1'b1; end
                    default:     e.alu_sel = 4'd0;
                endcase
            end
            P_M: begin
                e.iord = 1'b1; e.mem_read = (cls == C_LW); e.mem_write = (cls == C_SW);
                e.retire = rd && last;
            end
            P_W: begin
                e.reg_write = 1'b1; e.wb_sel = (cls == C_LW); e.retire = 1'b1;
            end
            default: e.halted = 1'b1;
        endcase
        return e;
    endfunction

    task automatic finish_phase();
        void'(ph.pop_front());
        if (ph.size() == 0) begin
            m_cnt = m_cnt + 32'd1;
            ph.push_back(P_F);
        end
    endtask

    task automatic model_step(input logic r, input logic [5:0] op, input logic rd);
        if (r) begin
            ph.delete();
            ph.push_back(P_F);
            m_cnt = 32'd0;
            return;
        end
        case (ph[0])
            P_F: if (rd) ph[0] = P_D;
            P_D: begin
                ph.delete();
                case (op_class(op))
                    C_ILL:        begin m_cnt = m_cnt + 32'd1; ph.push_back(P_F); end
                    C_HALT:       ph.push_back(P_H);
                    C_LW:         begin ph.push_back(P_E); ph.push_back(P_M); ph.push_back(P_W); end
                    C_SW:         begin ph.push_back(P_E); ph.push_back(P_M); end
                    C_BEQ, C_JMP: ph.push_back(P_E);
                    default:      begin ph.push_back(P_E); ph.push_back(P_W); end
                endcase
            end
            P_E, P_W: finish_phase();
            P_M: if (rd) finish_phase();
            default: ;
        endcase
    endtask

    task automatic cycle(input logic r, input logic [5:0] op, input logic f, input logic rd,
                         input bit use_tab, input outs_t te, input logic [31:0] tc);
        outs_t       e;
        logic [31:0] ec;
        rst = r; opcode = op; beq_flag = f; mem_ready = rd;
        #2;
        if (use_tab) begin
            e = te; ec = tc;
        end else begin
            e = model_exp(r, op, f, rd);
            ec = r ? 32'd0 : m_cnt;
        end
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, act, e);
        end
        checks++;
        if (instr_count !== ec) begin
            errors++;
            $display("FAIL instr_count cyc=%0d got=%0d exp=%0d", cyc, instr_count, ec);
        end
        last_act = act;
        $display("cyc=%0d rst=%0b op=%b flag=%0b rdy=%0b outs=%h cnt=%0d",
                 cyc, r, op, f, rd, act, instr_count);
        @(posedge clk);
        model_step(r, op, rd);
        #1;
        cyc++;
    endtask

    task automatic mc(input logic r, input logic [5:0] op, input logic f, input logic rd);
        cycle(r, op, f, rd, 1'b0, '0, 32'd0);
    endtask

    task automatic add_vec(input logic r, input logic [5:0] op, input logic f, input logic rd,
                           input outs_t e, input logic [31:0] c);
        vec_t v;
        v.r = r; v.op = op; v.flag = f; v.rdy = rd; v.exp = e; v.cnt = c;
        vecs.push_back(v);
    endtask

    initial begin
        outs_t      o_fetch_go, o_fetch_wait, o_dec, o_dec_ill, o_wb_alu;
        int         n_mem;
        int         halt_run;
        logic [5:0] op;
        int         sel;

        o_fetch_go   = mk(4'd2, 1, 2'd1, 1, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 0);
        o_fetch_wait = mk(4'd2, 1, 2'd1, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        o_dec        = mk(4'd2, 1, 2'd3, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        o_dec_ill    = mk(4'd2, 1, 2'd3, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0);
        o_wb_alu     = mk(4'd0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 1, 0, 0);

        add_vec(1, 6'h00, 0, 1, '0, 0);
        add_vec(0, 6'h00, 0, 1, o_fetch_go, 0);
        add_vec(0, 6'b000010, 0, 1, o_dec, 0);
        add_vec(0, 6'b000010, 0, 1, mk(4'd2, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0), 0);
        add_vec(0, 6'b000010, 0, 1, o_wb_alu, 0);
        add_vec(0, 6'h00, 0, 0, o_fetch_wait, 1);
        add_vec(0, 6'h00, 0, 1, o_fetch_go, 1);
        add_vec(0, 6'b000110, 0, 1, o_dec_ill, 1);
        add_vec(0, 6'h00, 0, 1, o_fetch_go, 2);
        add_vec(0, 6'b110000, 1, 1, o_dec, 2);
        add_vec(0, 6'b110000, 1, 1, mk(4'd3, 0, 2'd0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 1, 0, 0), 2);
        add_vec(0, 6'h00, 0, 1, o_fetch_go, 3);
        add_vec(0, 6'b101010, 0, 1, o_dec_ill, 3);
        add_vec(0, 6'h00, 0, 1, o_fetch_go, 4);
        add_vec(0, 6'b110001, 0, 1, o_dec, 4);
        add_vec(0, 6'b110001, 0, 1, mk(4'd0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 0, 0, 1, 0, 0), 4);
        add_vec(0, 6'h00, 0, 1, o_fetch_go, 5);
        add_vec(0, 6'b010111, 0, 1, o_dec, 5);
        add_vec(0, 6'b010111, 0, 1, mk(4'd7, 0, 2'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0), 5);
        add_vec(0, 6'b010111, 0, 1, o_wb_alu, 5);
        add_vec(0, 6'h00, 0, 0, o_fetch_wait, 6);

        ph.push_back(P_F);
        m_cnt = 32'd0;

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].op, vecs[i].flag, vecs[i].rdy, 1'b1, vecs[i].exp, vecs[i].cnt);
        end

        // beq not taken: no pc_write, still retires in EXEC.
        mc(0, 6'h00, 0, 1);
        mc(0, 6'b110000, 0, 1);
        mc(0, 6'b110000, 0, 1);

        // lw with two memory wait cycles: request and iord held for three cycles.
        n_mem = 0;
        mc(0, 6'h00, 0, 1);
        mc(0, 6'b100000, 0, 1);
        mc(0, 6'b100000, 0, 1);
        mc(0, 6'b100000, 0, 0); if (last_act.mem_read && last_act.iord) n_mem++;
        mc(0, 6'b100000, 1, 0); if (last_act.mem_read && last_act.iord) n_mem++;
        mc(0, 6'b100000, 0, 1); if (last_act.mem_read && last_act.iord) n_mem++;
        mc(0, 6'b100000, 0, 1);
        mc(0, 6'h00, 0, 0);
        checks++;
        if (n_mem != 3) begin
            errors++;
            $display("FAIL lw_mem_hold got=%0d exp=3", n_mem);
        end

        // halt: held for 20 cycles regardless of inputs, left only by reset.
        mc(0, 6'h00, 0, 1);
        mc(0, 6'b111111, 0, 1);
        for (int k = 0; k < 20; k++) begin
            mc(0, 6'b111111, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        mc(1, 6'b111111, 0, 1);
        mc(0, 6'h00, 0, 0);

        // Reset while sw waits in MEM aborts it.
        mc(0, 6'h00, 0, 1);
        mc(0, 6'b100001, 0, 1);
        mc(0, 6'b100001, 0, 1);
        mc(0, 6'b100001, 0, 0);
        mc(1, 6'b100001, 0, 0);
        mc(0, 6'h00, 0, 0);

        halt_run = 0;
        for (int k = 0; k < 1500; k++) begin
            if (ph[0] == P_F || ph[0] == P_H) begin
                sel = int'($urandom_range(0, 15));
                case (sel)
                    0, 1, 2, 3: op = {2'b00, 4'($urandom_range(0, 15))};
                    4, 5, 6:    op = {2'b01, 4'($urandom_range(0, 15))};
                    7, 8:       op = 6'b100000;
                    9, 10:      op = 6'b100001;
                    11:         op = 6'b110000;
                    12:         op = 6'b110001;
                    13:         op = 6'($urandom_range(0, 63));
                    14:         op = ($urandom_range(0, 3) == 0) ? 6'b111111 : 6'b000011;
                    default:    op = 6'b000010;
                endcase
            end
            halt_run = (ph[0] == P_H) ? halt_run + 1 : 0;
            mc(($urandom_range(0, 63) == 0) || (halt_run > 5), op,
               1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control FSM for the multicycle CPU. It sequences the shared ALU, register file, instruction register and unified memory through the fetch, decode, execute, memory and writeback phases. It decodes the 6-bit opcode held in the instruction register and drives the 4-bit ALU selection. It waits on the memory ready handshake and uses the ALU equality flag to resolve branches. It sits beside the datapath and is the only source of datapath write enables.

## Interface
Parameters:
- `OPW`, 6, opcode width.
- `CNTW`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26], stable from DECODE onward.
- `beq_flag`  in  1  ALU equality output (1 when A==B).
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `alu_sel`  out  4  ALU operation code.
- `alu_a_sel`  out  1  0 = register A, 1 = PC.
- `alu_b_sel`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `mem_read`, `mem_write`  out  1 each  memory request, held until `mem_ready`.
- `iord`  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- `ir_write`  out  1  latch the instruction register.
- `pc_write`  out  1  update the PC.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `reg_write`  out  1  register-file write.
- `wb_sel`  out  1  0 = ALUOut, 1 = memory data register.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `illegal`  out  1  one-cycle pulse in DECODE on an undefined opcode.
- `halted`  out  1  high while in HALT.
- `instr_count`  out  CNTW  number of retired instructions.

## Operation
Opcode classes:
- `00xxxx`: R-type; `alu_sel` = opcode[3:0], B operand = register.
- `01xxxx`: immediate ALU; `alu_sel` = opcode[3:0], B operand = imm. `011001` is Li.
- Legal ALU codes: 0000 mov, 0001 not, 0010 add, 0011 sub, 0100 or, 0101 and, 0111 slt, 1001 li. Any other code is illegal.
- `100000` lw, `100001` sw, `110000` beq, `110001` jmp, `111111` halt. All remaining opcodes are illegal.

States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Outputs: `mem_read`=1, `iord`=0, `alu_a_sel`=1, `alu_b_sel`=01, `alu_sel`=0010.
  - Without `mem_ready`: stay in FETCH with no enables.
  - With `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=00, then go to DECODE.
- DECODE:
  - Outputs: `alu_a_sel`=1, `alu_b_sel`=11, `alu_sel`=0010 (precompute the branch target).
  - Transitions: illegal opcode → pulse `illegal` and `retire` (executes as a NOP), then FETCH. halt → HALT. Everything else → EXEC.
- EXEC:
  - ALU classes: drive the ALU per class, then go to WB.
  - lw/sw: `alu_a_sel`=0, `alu_b_sel`=10, `alu_sel`=0010, then go to MEM.
  - beq: `alu_a_sel`=0, `alu_b_sel`=00, `alu_sel`=0011, `pc_src`=01, `pc_write`=`beq_flag`, `retire`=1, then FETCH.
  - jmp: `pc_write`=1, `pc_src`=10, `retire`=1, then FETCH.
- MEM:
  - Outputs: `iord`=1, with `mem_read` for lw or `mem_write` for sw, held until `mem_ready`.
  - On `mem_ready`: lw → WB; sw → pulse `retire`, then FETCH.
- WB: `reg_write`=1, `wb_sel`=1 for lw and 0 otherwise, `retire`=1, then FETCH.
- HALT: all enables 0, `halted`=1. Leaves HALT only on `rst`.

Counter and defaults:
- `instr_count` increments by 1 on every `retire` and wraps from 2^CNTW−1 to 0.
- `alu_sel` defaults to 0000 and every select to 0 when not specified above.

## Timing
Latencies, given as cycles from FETCH entry to `retire` with zero memory wait:
- beq and jmp: 3.
- Illegal opcode: 2.
- ALU ops and sw: 4.
- lw: 5.
- Each cycle `mem_ready` is low adds exactly one cycle.

Output behaviour:
- All outputs are decoded from the current state and `opcode`. Only the `mem_ready`-qualified strobes (`ir_write`, FETCH `pc_write`, MEM-exit `retire`) depend combinationally on `mem_ready`.
- While `rst`=1, every output is 0, including `alu_sel`=0000 and `halted`=0. On the rising edge with `rst`=1, the state becomes FETCH and `instr_count` becomes 0.
- Reset asserted mid-instruction (including while waiting in MEM) aborts the instruction: no `retire`, and no write enables in that cycle.

Handshake rules:
- `mem_read` and `mem_write` are never high together.
- A request is never withdrawn before `mem_ready`.
- `mem_ready` outside FETCH/MEM is ignored.

## Test plan
- Reset, then one add (`000010`), `mem_ready`=1: states FETCH→DECODE→EXEC→WB. EXEC shows `alu_sel`=0010. `reg_write` is high in cycle 4 and `instr_count`=1.
- lw (`100000`) with `mem_ready` low for 2 cycles in MEM: `mem_read` and `iord`=1 held 3 cycles. WB has `wb_sel`=1. Total is 7 cycles, then FETCH.
- beq with `beq_flag`=1 then `beq_flag`=0: `pc_write`=1 and `pc_src`=01 in EXEC for the first; `pc_write`=0 for the second. Both retire in 3 cycles.
- Opcode `000110` and opcode `101010`: `illegal` and `retire` pulse in DECODE, with no `reg_write`, `mem_write` or `pc_write` beyond fetch. Next state is FETCH.
- halt (`111111`): `halted`=1 held for 20 cycles with no enables. `rst` for 1 cycle gives FETCH with `instr_count`=0.
- `rst` asserted during a sw MEM wait: no `mem_write` in the reset cycle and no `retire`. The next cycle is FETCH with `mem_read`=1.
